// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and datapath widths.
// Reused by both the transmitter and the future receiver.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int UART_BITCNT_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        NINTH = 3'd4,
        STOP  = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// Asynchronous UART transmitter: TXREG holding register, TSR shift register
// and a baud-strobe driven FSM producing 8N1 or 9-bit frames on tx_out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txen,
    input  logic              tx9,
    input  logic              tx9d,
    input  logic              txreg_wr_en,
    input  logic [DATA_W-1:0] txreg_in,
    input  logic              uart_tx_shift_en,
    output logic              txif,
    output logic              trmt,
    output logic              tx_out
);

    localparam logic [UART_BITCNT_W-1:0] BIT_LAST = UART_BITCNT_W'(DATA_W - 1);

    uart_tx_state_t           state_r;
    logic [DATA_W-1:0]        txreg_r;
    logic                     txreg_full_r;
    logic [DATA_W:0]          tsr_r;
    logic [UART_BITCNT_W-1:0] bit_cnt_r;
    logic                     txen_q_r;
    logic                     tx_out_r;
    logic                     transfer_s;

    // TXREG->TSR handoff: from IDLE immediately, or from STOP on the strobe ending the stop bit.
    always_comb begin
        transfer_s = 1'b0;
        if (txen && txreg_full_r) begin
            transfer_s = (state_r == IDLE) || ((state_r == STOP) && uart_tx_shift_en);
        end else begin
            transfer_s = 1'b0;
        end
    end

    // TXREG holding register; a disable edge discards a pending byte, but writes made while disabled are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            txreg_r      <= {DATA_W{1'b0}};
            txreg_full_r <= 1'b0;
            txen_q_r     <= 1'b0;
        end else begin
            txen_q_r <= txen;
            if (txreg_wr_en) begin
                txreg_r      <= txreg_in;
                txreg_full_r <= 1'b1;
            end else if (txen_q_r && !txen) begin
                txreg_full_r <= 1'b0;
            end else if (transfer_s) begin
                txreg_full_r <= 1'b0;
            end else begin
                txreg_full_r <= txreg_full_r;
            end
        end
    end

    // Frame FSM with TSR shifter; every line change except the IDLE->WAIT load waits for the baud strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            tsr_r     <= {(DATA_W + 1){1'b0}};
            bit_cnt_r <= {UART_BITCNT_W{1'b0}};
            tx_out_r  <= 1'b1;
        end else if (!txen) begin
            state_r   <= IDLE;
            bit_cnt_r <= {UART_BITCNT_W{1'b0}};
            tx_out_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_out_r <= 1'b1;
                    if (transfer_s) begin
                        tsr_r   <= {tx9d, txreg_r};
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (uart_tx_shift_en) begin
                        state_r  <= START;
                        tx_out_r <= 1'b0;
                    end
                end
                START: begin
                    if (uart_tx_shift_en) begin
                        state_r   <= DATA;
                        tx_out_r  <= tsr_r[0];
                        bit_cnt_r <= {UART_BITCNT_W{1'b0}};
                    end
                end
                DATA: begin
                    // After the last data shift the ninth bit has moved down to tsr_r[1].
                    if (uart_tx_shift_en) begin
                        if (bit_cnt_r != BIT_LAST) begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                            tsr_r     <= {1'b0, tsr_r[DATA_W:1]};
                            tx_out_r  <= tsr_r[1];
                        end else if (tx9) begin
                            state_r  <= NINTH;
                            tx_out_r <= tsr_r[1];
                        end else begin
                            state_r  <= STOP;
                            tx_out_r <= 1'b1;
                        end
                    end
                end
                NINTH: begin
                    if (uart_tx_shift_en) begin
                        state_r  <= STOP;
                        tx_out_r <= 1'b1;
                    end
                end
                STOP: begin
                    if (uart_tx_shift_en) begin
                        if (transfer_s) begin
                            tsr_r    <= {tx9d, txreg_r};
                            state_r  <= START;
                            tx_out_r <= 1'b0;
                        end else begin
                            state_r  <= IDLE;
                            tx_out_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_out_r <= 1'b1;
                end
            endcase
        end
    end

    assign txif   = txen & ~txreg_full_r;
    assign trmt   = (state_r == IDLE);
    assign tx_out = tx_out_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: baud strobe every 16 clocks,
// line values compared bit by bit against hand-built frame patterns.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       txen;
    logic       tx9;
    logic       tx9d;
    logic       txreg_wr_en;
    logic [7:0] txreg_in;
    logic       uart_tx_shift_en;
    logic       txif;
    logic       trmt;
    logic       tx_out;

    int checks   = 0;
    int failures = 0;

    uart_tx dut (
        .clk              (clk),
        .rst              (rst),
        .txen             (txen),
        .tx9              (tx9),
        .tx9d             (tx9d),
        .txreg_wr_en      (txreg_wr_en),
        .txreg_in         (txreg_in),
        .uart_tx_shift_en (uart_tx_shift_en),
        .txif             (txif),
        .trmt             (trmt),
        .tx_out           (tx_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 1 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one baud period: 15 quiet clocks then a strobe clock
    task automatic tick();
        repeat (15) cyc();
        uart_tx_shift_en = 1'b1;
        cyc();
        uart_tx_shift_en = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        txreg_in    = d;
        txreg_wr_en = 1'b1;
        cyc();
        txreg_wr_en = 1'b0;
    endtask

    // index 0 = start bit, 1..8 data LSB first, then stop (and ninth bit for 9-bit)
    function automatic logic [10:0] seq8(input logic [7:0] d);
        return {1'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [10:0] seq9(input logic [7:0] d, input logic b9);
        return {1'b1, b9, d, 1'b0};
    endfunction

    task automatic run_frame(input logic [10:0] seq, input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            tick();
            check($sformatf("%s_bit%0d", tag, i), {15'd0, tx_out}, {15'd0, seq[i]});
            check($sformatf("%s_trmt%0d", tag, i), {15'd0, trmt}, 16'd0);
        end
    endtask

    initial begin
        rst = 1'b1; txen = 1'b0; tx9 = 1'b0; tx9d = 1'b0;
        txreg_wr_en = 1'b0; txreg_in = 8'h00; uart_tx_shift_en = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // 1. reset state
        check("rst_tx_out", {15'd0, tx_out}, 16'd1);
        check("rst_trmt",   {15'd0, trmt},   16'd1);
        check("rst_txif",   {15'd0, txif},   16'd0);
        txen = 1'b1;
        cyc();
        check("en_txif", {15'd0, txif}, 16'd1);

        // 2. 8N1 frame 0xA5
        write(8'hA5);
        check("a5_txif_full", {15'd0, txif}, 16'd0);
        check("a5_trmt_pre",  {15'd0, trmt}, 16'd1);
        cyc();
        check("a5_trmt_xfer", {15'd0, trmt}, 16'd0);
        check("a5_txif_xfer", {15'd0, txif}, 16'd1);
        run_frame(seq8(8'hA5), 0, 9, "a5");
        tick();
        check("a5_trmt_end", {15'd0, trmt},   16'd1);
        check("a5_line_end", {15'd0, tx_out}, 16'd1);

        // 3. 9-bit frame 0x00 with ninth bit 1
        tx9 = 1'b1; tx9d = 1'b1;
        write(8'h00);
        cyc();
        run_frame(seq9(8'h00, 1'b1), 0, 10, "n9");
        tick();
        check("n9_trmt_end", {15'd0, trmt}, 16'd1);
        tx9 = 1'b0; tx9d = 1'b0;

        // 4. back-to-back 0x55 then 0x0F
        write(8'h55);
        cyc();
        run_frame(seq8(8'h55), 0, 2, "b1");
        write(8'h0F);
        check("b2_txif_pend", {15'd0, txif}, 16'd0);
        for (int i = 3; i <= 9; i++) begin
            tick();
            check($sformatf("b1_bit%0d", i), {15'd0, tx_out}, {15'd0, seq8(8'h55) >> i} & 16'd1);
            check($sformatf("b1_trmt%0d", i), {15'd0, trmt}, 16'd0);
            check($sformatf("b1_txif%0d", i), {15'd0, txif}, 16'd0);
        end
        tick();
        check("b2_start",     {15'd0, tx_out}, 16'd0);
        check("b2_trmt",      {15'd0, trmt},   16'd0);
        check("b2_txif_xfer", {15'd0, txif},   16'd1);
        run_frame(seq8(8'h0F), 1, 9, "b2");
        tick();
        check("b2_trmt_end", {15'd0, trmt}, 16'd1);

        // 5. write while disabled, then enable
        txen = 1'b0;
        cyc();
        write(8'h3C);
        tick();
        check("dis_line", {15'd0, tx_out}, 16'd1);
        check("dis_trmt", {15'd0, trmt},   16'd1);
        check("dis_txif", {15'd0, txif},   16'd0);
        txen = 1'b1;
        cyc();
        check("en_trmt_xfer", {15'd0, trmt}, 16'd0);
        check("en_txif_xfer", {15'd0, txif}, 16'd1);
        run_frame(seq8(8'h3C), 0, 9, "c3");
        tick();
        check("c3_trmt_end", {15'd0, trmt}, 16'd1);

        // 6a. abort by txen during data bit 3, pending byte discarded
        write(8'h00);
        cyc();
        run_frame(seq8(8'h00), 0, 2, "ab");
        write(8'h00);
        run_frame(seq8(8'h00), 3, 4, "ab");
        txen = 1'b0;
        cyc();
        check("ab_line", {15'd0, tx_out}, 16'd1);
        check("ab_trmt", {15'd0, trmt},   16'd1);
        check("ab_txif", {15'd0, txif},   16'd0);
        txen = 1'b1;
        cyc();
        check("ab_no_pend_trmt", {15'd0, trmt}, 16'd1);
        check("ab_no_pend_txif", {15'd0, txif}, 16'd1);
        tick();
        check("ab_idle_line", {15'd0, tx_out}, 16'd1);
        check("ab_idle_trmt", {15'd0, trmt},   16'd1);

        // 6b. reset mid-frame
        write(8'h00);
        cyc();
        run_frame(seq8(8'h00), 0, 4, "rs");
        write(8'h00);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rs_line", {15'd0, tx_out}, 16'd1);
        check("rs_trmt", {15'd0, trmt},   16'd1);
        check("rs_txif", {15'd0, txif},   16'd1);
        tick();
        check("rs_idle_line", {15'd0, tx_out}, 16'd1);
        check("rs_idle_trmt", {15'd0, trmt},   16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
